// File: rtl/gpio_apb_ctrl_if.sv
// APB3 bus bundle between a fabric master and the gpio_apb_ctrl slave.
// An access commits when PSEL & PENABLE are high; PREADY is always 1, so every access phase lasts exactly one clock.
interface gpio_apb_ctrl_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [4:0]  PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                   input  PRDATA, PREADY, PSLVERR);
   modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                   output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/gpio_apb_ctrl.sv
// APB3 GPIO bank: registered outputs/enables, synchronised inputs, edge interrupts.
// Define GPIO_DEBOUNCE_EN to add the shared prescaler and the 3-sample input filter.
module gpio_apb_ctrl #(
   parameter int unsigned     NUM_GPIO   = 8,
   parameter int unsigned     DB_W       = 16,
   parameter logic [DB_W-1:0] DB_DEFAULT = 16'd999
) (
   input  logic                FAB_CCC_GL0,
   input  logic                FAB_RESET,
   gpio_apb_ctrl_if.slave      apb,
   input  logic [NUM_GPIO-1:0] GPIO_IN,
   output logic [NUM_GPIO-1:0] GPIO_OUT,
   output logic [NUM_GPIO-1:0] GPIO_OE,
   output logic                GPIO_IRQ
);
   typedef logic [NUM_GPIO-1:0] vec_t;

   vec_t            out_r, oe_r, irq_en_r, irq_stat_r, pol_r;
   vec_t            sync1, sync2, stable;
   logic [1:0]      sync_vld;
   logic            armed;
   logic            access, wr;
   logic [2:0]      idx;
   vec_t            wdata, w1c, stable_next, edge_set;
   logic            stable_upd;
   logic [DB_W-1:0] db_rd;
   logic [31:0]     rdata;
   logic            slverr;
   logic            unused_bits;

   assign access      = apb.PSEL & apb.PENABLE;
   assign wr          = access & apb.PWRITE;
   assign idx         = apb.PADDR[4:2];
   assign wdata       = apb.PWDATA[NUM_GPIO-1:0];
   assign w1c         = (wr && idx == 3'd4) ? wdata : '0;
   assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

`ifdef GPIO_DEBOUNCE_EN
   logic [DB_W-1:0] db_r, db_cnt;
   logic [1:0]      hist_fill;
   vec_t            hist0, hist1, agree;
   logic            cnt_wrap, sample;

   assign cnt_wrap    = (db_cnt == db_r);
   assign sample      = cnt_wrap & sync_vld[1];
   assign agree       = ~(sync2 ^ hist0) & ~(sync2 ^ hist1);
   assign stable_next = (stable & ~agree) | (sync2 & agree);
   // Only judge the filter once its history holds two real samples.
   assign stable_upd  = sample & hist_fill[1];
   assign db_rd       = db_r;

   always_ff @(posedge FAB_CCC_GL0) begin
      if (FAB_RESET) begin
         db_r      <= DB_DEFAULT;
         db_cnt    <= '0;
         hist0     <= '0;
         hist1     <= '0;
         hist_fill <= '0;
      end else begin
         if (wr && idx == 3'd6) begin
            db_r   <= apb.PWDATA[DB_W-1:0];
            db_cnt <= '0;
         end else if (cnt_wrap) begin
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
         if (sample) begin
            hist0     <= sync2;
            hist1     <= hist0;
            hist_fill <= {hist_fill[0], 1'b1};
         end
      end
   end
`else
   localparam logic [DB_W-1:0] DB_NONE = DB_DEFAULT ^ DB_DEFAULT;

   assign stable_next = sync2;
   assign stable_upd  = sync_vld[1];
   assign db_rd       = DB_NONE;
`endif

   // The first update after reset only loads stable, so a pad already high never looks like an edge.
   assign edge_set = (armed && stable_upd)
                     ? ((stable_next & ~stable & pol_r) | (~stable_next & stable & ~pol_r))
                     : '0;

   always_ff @(posedge FAB_CCC_GL0) begin
      if (FAB_RESET) begin
         out_r      <= '0;
         oe_r       <= '0;
         irq_en_r   <= '0;
         irq_stat_r <= '0;
         pol_r      <= '1;
         sync1      <= '0;
         sync2      <= '0;
         sync_vld   <= '0;
         stable     <= '0;
         armed      <= 1'b0;
      end else begin
         sync1    <= GPIO_IN;
         sync2    <= sync1;
         sync_vld <= {sync_vld[0], 1'b1};
         if (stable_upd) begin
            stable <= stable_next;
            armed  <= 1'b1;
         end
         // A hardware set on the same edge as a W1C keeps the bit set.
         irq_stat_r <= edge_set | (irq_stat_r & ~w1c);
         if (wr) begin
            case (idx)
               3'd0:    out_r    <= wdata;
               3'd1:    oe_r     <= wdata;
               3'd3:    irq_en_r <= wdata;
               3'd5:    pol_r    <= wdata;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rdata  = '0;
      slverr = 1'b0;
      if (access) begin
         case (idx)
            3'd0:    rdata[NUM_GPIO-1:0] = out_r;
            3'd1:    rdata[NUM_GPIO-1:0] = oe_r;
            3'd2:    rdata[NUM_GPIO-1:0] = stable;
            3'd3:    rdata[NUM_GPIO-1:0] = irq_en_r;
            3'd4:    rdata[NUM_GPIO-1:0] = irq_stat_r;
            3'd5:    rdata[NUM_GPIO-1:0] = pol_r;
            3'd6:    rdata[DB_W-1:0]     = db_rd;
            default: slverr = 1'b1;
         endcase
      end
   end

   assign apb.PRDATA  = rdata;
   assign apb.PSLVERR = slverr;
   assign apb.PREADY  = 1'b1;
   assign GPIO_OUT    = out_r;
   assign GPIO_OE     = oe_r;
   assign GPIO_IRQ    = |(irq_stat_r & irq_en_r);
endmodule
